// File: rtl/app_read32_fifo.sv
// rtl/app_read32_fifo.sv - 32-bit application-to-host read FIFO with end-of-file and close flush
// A count-based synchronous FIFO. Closing the host file discards staged data and any pending eof.
module app_read32_fifo #(
   parameter int DEPTH_LOG2 = 9
) (
   input  logic                  bus_clk_w,
   input  logic                  bus_rst_w,
   input  logic [31:0]           app_data_w,
   input  logic                  app_wren_w,
   input  logic                  app_eof_w,
   output logic                  app_full_w,
   output logic [DEPTH_LOG2:0]   app_fill_w,
   output logic                  app_overflow_w,
   input  logic                  user_r_read_32_rden_w,
   input  logic                  user_r_read_32_open_w,
   output logic [31:0]           user_r_read_32_data_w,
   output logic                  user_r_read_32_empty_w,
   output logic                  user_r_read_32_eof_w
);

   localparam int                    DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

   logic [31:0]           mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic [31:0]           data_q, data_d;
   logic                  eof_pend_q, eof_pend_d;
   logic                  ovf_q, ovf_d;
   logic                  open_prev_q;
   logic                  empty, full, flush, wr_ok, rd_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_C);
   assign flush = open_prev_q & ~user_r_read_32_open_w;
   assign wr_ok = app_wren_w & ~full & ~flush;
   assign rd_ok = user_r_read_32_rden_w & ~empty & ~flush;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      data_d     = data_q;
      eof_pend_d = eof_pend_q;
      ovf_d      = ovf_q;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         eof_pend_d = 1'b0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            data_d   = mem_q[rd_ptr_q];
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         if (app_eof_w) eof_pend_d = 1'b1;
         if (app_wren_w && full) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge bus_clk_w or posedge bus_rst_w) begin
      if (bus_rst_w) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         data_q      <= '0;
         eof_pend_q  <= 1'b0;
         ovf_q       <= 1'b0;
         open_prev_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         data_q      <= data_d;
         eof_pend_q  <= eof_pend_d;
         ovf_q       <= ovf_d;
         open_prev_q <= user_r_read_32_open_w;
      end
   end

   // Storage carries no reset; a location is only read after it has been written.
   always_ff @(posedge bus_clk_w) begin
      if (wr_ok) mem_q[wr_ptr_q] <= app_data_w;
   end

   assign app_full_w             = full;
   assign app_fill_w             = count_q;
   assign app_overflow_w         = ovf_q;
   assign user_r_read_32_data_w  = data_q;
   assign user_r_read_32_empty_w = empty;
   assign user_r_read_32_eof_w   = eof_pend_q & empty;

endmodule

// File: doc/app_read32_fifo.md
APP_READ32_FIFO -- requirements
Module: app_read32_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 9, log2 of FIFO depth in 32-bit words (depth 512).
REQ-002 SHALL have port bus_clk_w, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port bus_rst_w, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port app_data_w, input, 32, application write data.
REQ-005 SHALL have port app_wren_w, input, 1, application write strobe.
REQ-006 SHALL have port app_eof_w, input, 1, single-cycle end-of-stream mark, applied after any word written the same cycle.
REQ-007 SHALL have port app_full_w, output, 1, FIFO full.
REQ-008 SHALL have port app_fill_w, output, DEPTH_LOG2+1, current word count.
REQ-009 SHALL have port app_overflow_w, output, 1, sticky flag for a write dropped while full.
REQ-010 SHALL have port user_r_read_32_rden_w, input, 1, read strobe from the core.
REQ-011 SHALL have port user_r_read_32_open_w, input, 1, host file open.
REQ-012 SHALL have port user_r_read_32_data_w, output, 32, read data to the core.
REQ-013 SHALL have port user_r_read_32_empty_w, output, 1, no word available.
REQ-014 SHALL have port user_r_read_32_eof_w, output, 1, end-of-file to the core.

Function
REQ-015 SHALL implement a synchronous FIFO with 2^DEPTH_LOG2 words, binary read/write pointers and a DEPTH_LOG2+1-bit count.
REQ-016 SHALL accept a write when app_wren_w=1 and count<depth; SHALL drop it otherwise and set app_overflow_w.
REQ-017 SHALL base full on the registered count, so a write at full is dropped even if a read occurs the same cycle.
REQ-018 SHALL accept a read when rden=1 and count>0.
REQ-019 SHALL present accepted read data on user_r_read_32_data_w exactly one cycle after rden.
REQ-020 SHALL hold data unchanged when no read is accepted; SHALL ignore rden while empty.
REQ-021 SHALL treat a simultaneous accepted read and write as net count change 0.
REQ-022 SHALL, at count=0, accept a simultaneous write and ignore the read.
REQ-023 SHALL wrap both pointers modulo depth with no gap or duplicated word.
REQ-024 SHALL drive empty = (count==0) and app_full_w = (count==depth); both registered, combinational from count only.
REQ-025 SHALL set an internal eof_pending flag on app_eof_w=1.
REQ-026 SHALL drive user_r_read_32_eof_w = eof_pending AND empty, so eof is never high while data remains.
REQ-027 SHALL, on the cycle after a 1->0 transition of user_r_read_32_open_w, flush the FIFO (count 0, pointers equal) and clear eof_pending.
REQ-028 SHALL give the flush priority over a same-cycle app_eof_w and write; both are discarded.
REQ-029 SHALL accept writes and eof marks while open=0, so data may be staged before the host opens the file.
REQ-030 SHALL drive app_fill_w with the count value.
REQ-031 SHALL clear app_overflow_w only on reset.

Reset
REQ-032 SHALL, on bus_rst_w=1, asynchronously set count, pointers, eof_pending, app_overflow_w and data output to 0.
REQ-033 SHALL therefore drive empty=1, full=0 and eof=0 during reset.
REQ-034 SHALL, when reset asserts mid-transfer, discard all stored words and any pending eof; the previous open level register resets to 0.
REQ-035 SHALL leave memory array contents unreset; they are not observable until rewritten.

Verification
REQ-036 SHALL cover basic transfer: write 0x11111111, 0x22222222, 0x33333333, then rden for 3 cycles -> data 0x11111111 / 0x22222222 / 0x33333333 on the cycles after each rden; empty=1 after the third.
REQ-037 SHALL cover full/overflow: write 513 words with no reads -> full=1 at count 512; the 513th is dropped; overflow=1; reading 512 returns words 0..511 in order.
REQ-038 SHALL cover EOF ordering: open=1, write 2 words with app_eof_w on the second write -> eof=0 while count>0; eof=1 with empty=1 on the cycle after the second read is accepted.
REQ-039 SHALL cover close flush: 10 words stored with eof_pending, then open 1->0 -> count=0, eof=0 on the next cycle; a new write then gives count=1.
REQ-040 SHALL cover simultaneous read and write at count=0 and at count=1 -> count 1 and 1 respectively; read data correct; with DEPTH_LOG2=2, 20 words streamed through cross the pointer wrap with no loss.
REQ-041 SHALL cover reset mid-stream: assert bus_rst_w with 5 words and eof pending -> empty=1, eof=0, overflow=0, data=0 immediately, without waiting for a clock edge.
